// File: rtl/sd_result_fifo.sv
// Result FIFO behind the sphere-decoder search: packs the four best-node indices, tags the
// search duration and buffers words for a valid/ready consumer. Gray mapping: SD_RESULT_GRAY_MAP_EN.
module sd_result_fifo #(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     InReady,
  input  logic [2:0]               InData0,
  input  logic [2:0]               InData1,
  input  logic [2:0]               InData2,
  input  logic [2:0]               InData3,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [11:0]              OutWord,
  output logic [CNT_WIDTH-1:0]     OutCycles,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [11:0]          word;
    logic [CNT_WIDTH-1:0] cycles;
  } entry_t;

  function automatic logic [2:0] map_sym(input logic [2:0] b);
`ifdef SD_RESULT_GRAY_MAP_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  entry_t               mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CNT_WIDTH-1:0] dur_q, dur_d;
  logic                 overflow_q, overflow_d;
  logic                 push, pop, full, drop;
  entry_t               new_entry;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    full       = (count_q == CW'(DEPTH));
    pop        = (count_q != '0) && OutReady;
    push       = InReady && (!full || pop);
    drop       = InReady && full && !pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;

    new_entry.word   = {map_sym(InData3), map_sym(InData2), map_sym(InData1), map_sym(InData0)};
    new_entry.cycles = dur_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Every pulse restarts the duration count, even one whose entry gets dropped.
    if (InReady)     dur_d = '0;
    else if (&dur_q) dur_d = dur_q;
    else             dur_d = dur_q + CNT_WIDTH'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from
  // pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dur_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dur_q      <= dur_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; stale contents are never visible because
  // the outputs are masked while Count is zero.
  always_ff @(posedge Clk) begin
    if (push && !Reset) mem_q[wr_ptr_q] <= new_entry;
  end

  entry_t head;

  always_comb begin
    head      = mem_q[rd_ptr_q];
    OutValid  = (count_q != '0);
    OutWord   = OutValid ? head.word   : '0;
    OutCycles = OutValid ? head.cycles : '0;
    Count     = count_q;
    Full      = full;
    Overflow  = overflow_q;
  end

endmodule

// File: tb/tb_sd_result_fifo.sv
// Self-checking bench for sd_result_fifo: directed scenarios plus randomized traffic,
// compared against a queue-based model of the result FIFO.
module tb_sd_result_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int MAXC  = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          InReady = 1'b0;
  logic [2:0]    InData0 = '0, InData1 = '0, InData2 = '0, InData3 = '0;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic [11:0]   OutWord;
  logic [CW-1:0] OutCycles;
  logic [2:0]    Count;
  logic          Full;
  logic          Overflow;

  sd_result_fifo #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .Clk(Clk), .Reset(Reset), .InReady(InReady),
    .InData0(InData0), .InData1(InData1), .InData2(InData2), .InData3(InData3),
    .OutValid(OutValid), .OutReady(OutReady), .OutWord(OutWord), .OutCycles(OutCycles),
    .Count(Count), .Full(Full), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int word;
    int cyc;
  } ent_t;

  ent_t mq[$];
  int   idle;
  bit   ovf;
  int   gray_lut [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
  int   checks = 0;
  int   passes = 0;

  function automatic int sym(input int b);
`ifdef SD_RESULT_GRAY_MAP_EN
    return gray_lut[b];
`else
    return b;
`endif
  endfunction

  function automatic int pack(input int d3, input int d2, input int d1, input int d0);
    return sym(d3) * 512 + sym(d2) * 64 + sym(d1) * 8 + sym(d0);
  endfunction

  function automatic int exp_word();
    return (mq.size() != 0) ? mq[0].word : 0;
  endfunction

  function automatic int exp_cyc();
    return (mq.size() != 0) ? mq[0].cyc : 0;
  endfunction

  // One clock: drive inputs, advance the model by the FIFO rules, settle 1ns past the edge.
  task automatic tick(input bit rst, input bit ir, input int d3, input int d2,
                      input int d1, input int d0, input bit ordy);
    ent_t e;
    Reset = rst; InReady = ir; OutReady = ordy;
    InData3 = 3'(d3); InData2 = 3'(d2); InData1 = 3'(d1); InData0 = 3'(d0);
    if (rst) begin
      mq.delete(); idle = 0; ovf = 0;
    end else begin
      if (mq.size() != 0 && ordy) void'(mq.pop_front());
      if (ir) begin
        if (mq.size() < DEPTH) begin
          e.word = pack(d3, d2, d1, d0);
          e.cyc  = (idle > MAXC) ? MAXC : idle;
          mq.push_back(e);
        end else ovf = 1;
      end
      idle = ir ? 0 : idle + 1;
    end
    @(posedge Clk); #1;
    Reset = 1'b0; InReady = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input bit ordy);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, ordy);
  endtask

  task automatic rand_pulse(input bit ordy);
    tick(0, 1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
         $urandom_range(0, 7), ordy);
  endtask

  task automatic do_reset();
    tick(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (OutValid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", OutValid); else passes++;
    checks++; if (Count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", Count); else passes++;
    checks++; if (Full !== 1'b0) $display("FAIL reset_full: got %b expected 0", Full); else passes++;
    checks++; if (Overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", Overflow); else passes++;
    checks++; if (OutWord !== 12'd0 || OutCycles !== '0)
      $display("FAIL reset_outputs: got word %h cycles %0d expected 0/0", OutWord, OutCycles); else passes++;
  endtask

  task automatic test_single();
    logic [11:0] lit;
`ifdef SD_RESULT_GRAY_MAP_EN
    lit = 12'o4371;
`else
    lit = 12'o7251;
`endif
    do_reset();
    idle_cycles(10, 0);
    tick(0, 1, 7, 2, 5, 1, 0);
    checks++; if (OutValid !== 1'b1) $display("FAIL single_valid: got %b expected 1", OutValid); else passes++;
    checks++; if (OutWord !== lit) $display("FAIL single_word: got %o expected %o", OutWord, lit); else passes++;
    checks++; if (OutWord !== 12'(exp_word())) $display("FAIL single_word_model: got %o expected %o", OutWord, exp_word()); else passes++;
    checks++; if (OutCycles !== 4'd10) $display("FAIL single_cycles: got %0d expected 10", OutCycles); else passes++;
    checks++; if (Count !== 3'd1) $display("FAIL single_count: got %0d expected 1", Count); else passes++;
    idle_cycles(2, 0);
    checks++; if (OutWord !== lit) $display("FAIL single_stable: got %o expected %o", OutWord, lit); else passes++;
    idle_cycles(1, 1);
    checks++; if (OutValid !== 1'b0) $display("FAIL single_pop_valid: got %b expected 0", OutValid); else passes++;
    checks++; if (Count !== 3'd0) $display("FAIL single_pop_count: got %0d expected 0", Count); else passes++;
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int p = 0; p < 5; p++) begin
      if (p != 0) idle_cycles(2, 0);
      rand_pulse(0);
      checks++; if (Count !== 3'(mq.size())) $display("FAIL fill_count_%0d: got %0d expected %0d", p, Count, mq.size()); else passes++;
      checks++; if (Full !== (p >= 3)) $display("FAIL fill_full_%0d: got %b expected %b", p, Full, p >= 3); else passes++;
      checks++; if (Overflow !== (p == 4)) $display("FAIL fill_overflow_%0d: got %b expected %b", p, Overflow, p == 4); else passes++;
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (OutWord !== 12'(exp_word())) $display("FAIL drain_word_%0d: got %o expected %o", i, OutWord, exp_word()); else passes++;
      checks++; if (OutCycles !== 4'((i == 0) ? 0 : 2)) $display("FAIL drain_cycles_%0d: got %0d expected %0d", i, OutCycles, (i == 0) ? 0 : 2); else passes++;
      idle_cycles(1, 1);
    end
    checks++; if (OutValid !== 1'b0) $display("FAIL drain_empty: got %b expected 0", OutValid); else passes++;
    checks++; if (Overflow !== 1'b1) $display("FAIL overflow_sticky: got %b expected 1", Overflow); else passes++;
  endtask

  task automatic test_full_push_pop();
    int new_word;
    do_reset();
    for (int p = 0; p < DEPTH; p++) rand_pulse(0);
    new_word = pack(6, 3, 0, 5);
    tick(0, 1, 6, 3, 0, 5, 1);
    checks++; if (Count !== 3'd4) $display("FAIL pp_count: got %0d expected 4", Count); else passes++;
    checks++; if (Overflow !== 1'b0) $display("FAIL pp_overflow: got %b expected 0", Overflow); else passes++;
    checks++; if (Full !== 1'b1) $display("FAIL pp_full: got %b expected 1", Full); else passes++;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        checks++; if (OutWord !== 12'(new_word)) $display("FAIL pp_last_word: got %o expected %o", OutWord, new_word); else passes++;
      end
      checks++; if (OutWord !== 12'(exp_word())) $display("FAIL pp_drain_%0d: got %o expected %o", i, OutWord, exp_word()); else passes++;
      idle_cycles(1, 1);
    end
    checks++; if (Count !== 3'd0) $display("FAIL pp_empty: got %0d expected 0", Count); else passes++;
  endtask

  task automatic test_saturation();
    do_reset();
    idle_cycles(20, 0);
    rand_pulse(0);
    idle_cycles(2, 0);
    rand_pulse(0);
    checks++; if (OutCycles !== 4'd15) $display("FAIL sat_cycles: got %0d expected 15", OutCycles); else passes++;
    idle_cycles(1, 1);
    checks++; if (OutCycles !== 4'd2) $display("FAIL sat_next_cycles: got %0d expected 2", OutCycles); else passes++;
    checks++; if (OutCycles !== 4'(exp_cyc())) $display("FAIL sat_model: got %0d expected %0d", OutCycles, exp_cyc()); else passes++;
    idle_cycles(1, 1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int p = 0; p < 5; p++) rand_pulse(0);
    idle_cycles(1, 1);
    checks++; if (Count !== 3'd3 || Overflow !== 1'b1)
      $display("FAIL mid_setup: got count %0d ovf %b expected 3/1", Count, Overflow); else passes++;
    tick(1, 1, 7, 7, 7, 7, 0);
    checks++; if (Count !== 3'd0) $display("FAIL mid_count: got %0d expected 0", Count); else passes++;
    checks++; if (OutValid !== 1'b0) $display("FAIL mid_valid: got %b expected 0", OutValid); else passes++;
    checks++; if (Overflow !== 1'b0) $display("FAIL mid_overflow: got %b expected 0", Overflow); else passes++;
    idle_cycles(4, 0);
    rand_pulse(0);
    checks++; if (OutCycles !== 4'd4) $display("FAIL mid_cycles: got %0d expected 4", OutCycles); else passes++;
    checks++; if (Count !== 3'd1) $display("FAIL mid_count_after: got %0d expected 1", Count); else passes++;
  endtask

  task automatic test_random();
    bit ir, ordy, rst;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 99) == 0);
      ir   = ($urandom_range(0, 2) == 0);
      ordy = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick(rst, ir, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), ordy);
      checks++; if (OutValid !== (mq.size() != 0)) $display("FAIL rnd_valid_%0d: got %b expected %b", c, OutValid, mq.size() != 0); else passes++;
      checks++; if (OutWord !== 12'(exp_word())) $display("FAIL rnd_word_%0d: got %o expected %o", c, OutWord, exp_word()); else passes++;
      checks++; if (OutCycles !== 4'(exp_cyc())) $display("FAIL rnd_cycles_%0d: got %0d expected %0d", c, OutCycles, exp_cyc()); else passes++;
      checks++; if (Count !== 3'(mq.size())) $display("FAIL rnd_count_%0d: got %0d expected %0d", c, Count, mq.size()); else passes++;
      checks++; if (Full !== (mq.size() == DEPTH)) $display("FAIL rnd_full_%0d: got %b expected %b", c, Full, mq.size() == DEPTH); else passes++;
      checks++; if (Overflow !== ovf) $display("FAIL rnd_overflow_%0d: got %b expected %b", c, Overflow, ovf); else passes++;
    end
  endtask

  initial begin
    idle = 0;
    ovf  = 0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
